// File: rtl/pc_gen_if.sv
// Fetch-stage control/status bundle between the pipeline and the program-counter generator.
interface pc_gen_if #(
  parameter int unsigned XLEN = 32
) ();

  logic            stall;
  logic            redirect;
  logic [XLEN-1:0] redirect_pc;
  logic            trap;
  logic [XLEN-1:0] trap_vec;
  logic            call;
  logic            ret;
  logic            halt_req;
  logic            resume;

  logic [XLEN-1:0] pc;
  logic            pc_valid;
  logic            ras_empty;
  logic            ras_full;
  logic [1:0]      state;

  // Pipeline side: drives control, observes the fetch address.
  modport master (
    output stall, redirect, redirect_pc, trap, trap_vec, call, ret, halt_req, resume,
    input  pc, pc_valid, ras_empty, ras_full, state
  );

  // Generator side.
  modport slave (
    input  stall, redirect, redirect_pc, trap, trap_vec, call, ret, halt_req, resume,
    output pc, pc_valid, ras_empty, ras_full, state
  );

endinterface

// File: rtl/pc_gen.sv
// Program-counter generator: boot delay, halt/resume, trap vectoring, branch redirect
// and a circular return-address stack that predicts returns.
module pc_gen #(
  parameter int unsigned      XLEN         = 32,
  parameter logic [XLEN-1:0]  RESET_VECTOR = '0,
  parameter int unsigned      BOOT_CYCLES  = 2,
  parameter int unsigned      RAS_DEPTH    = 4
) (
  input  logic      clk,
  input  logic      rst,
  pc_gen_if.slave   bus
);

  localparam int unsigned PTR_W  = $clog2(RAS_DEPTH);
  localparam int unsigned CNT_W  = PTR_W + 1;
  localparam int unsigned BOOT_W = 8;

  // BOOT lasts BOOT_CYCLES clocks; 0 and 1 both leave on the first edge.
  localparam logic [BOOT_W-1:0] BOOT_LAST =
    (BOOT_CYCLES == 0) ? BOOT_W'(0) : BOOT_W'(BOOT_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_BOOT = 2'b00,
    ST_RUN  = 2'b01,
    ST_HALT = 2'b10
  } state_e;

  state_e              state_q,     state_d;
  logic [XLEN-1:0]     pc_q,        pc_d;
  logic [BOOT_W-1:0]   boot_cnt_q,  boot_cnt_d;
  logic [PTR_W-1:0]    ras_ptr_q,   ras_ptr_d;
  logic [CNT_W-1:0]    ras_cnt_q,   ras_cnt_d;
  logic                pc_valid_q;
  logic                ras_empty_q;
  logic                ras_full_q;

  logic [XLEN-1:0]     ras_mem [RAS_DEPTH];
  logic                ras_we;
  logic [PTR_W-1:0]    ras_waddr;
  logic [XLEN-1:0]     ras_wdata;

  logic [XLEN-1:0]     pc_seq;
  logic [XLEN-1:0]     ras_top;
  logic                ras_has_entry;

  // Instruction fetches are word aligned; loaded targets drop the low two bits.
  function automatic logic [XLEN-1:0] align(input logic [XLEN-1:0] a);
    return a & ~XLEN'(3);
  endfunction

  assign pc_seq        = pc_q + XLEN'(4);
  assign ras_top       = ras_mem[ras_ptr_q];
  assign ras_has_entry = (ras_cnt_q != CNT_W'(0));

  // Next-state, next-pc and RAS update.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    boot_cnt_d = boot_cnt_q;
    ras_ptr_d  = ras_ptr_q;
    ras_cnt_d  = ras_cnt_q;
    ras_we     = 1'b0;
    ras_waddr  = ras_ptr_q;
    ras_wdata  = pc_seq;

    case (state_q)
      ST_BOOT: begin
        pc_d = RESET_VECTOR;
        if (boot_cnt_q == BOOT_LAST) begin
          state_d = ST_RUN;
        end else begin
          boot_cnt_d = boot_cnt_q + BOOT_W'(1);
        end
      end

      ST_RUN: begin
        if (bus.trap) begin
          pc_d = align(bus.trap_vec);
        end else if (bus.redirect) begin
          pc_d = align(bus.redirect_pc);
        end else if (bus.stall) begin
          pc_d = pc_q;
        end else if (bus.ret && ras_has_entry) begin
          pc_d = ras_top;
          if (bus.call) begin
            // Call and return together: swap the top entry, depth unchanged.
            ras_we    = 1'b1;
            ras_waddr = ras_ptr_q;
          end else begin
            ras_ptr_d = ras_ptr_q - PTR_W'(1);
            ras_cnt_d = ras_cnt_q - CNT_W'(1);
          end
        end else begin
          pc_d = pc_seq;
          if (bus.call) begin
            // Circular push: when full the slot after the top holds the oldest entry.
            ras_we    = 1'b1;
            ras_waddr = ras_ptr_q + PTR_W'(1);
            ras_ptr_d = ras_ptr_q + PTR_W'(1);
            if (ras_cnt_q != CNT_W'(RAS_DEPTH)) begin
              ras_cnt_d = ras_cnt_q + CNT_W'(1);
            end
          end
        end

        if (bus.halt_req && !bus.trap && !bus.redirect) begin
          state_d = ST_HALT;
        end
      end

      ST_HALT: begin
        if (bus.trap) begin
          pc_d    = align(bus.trap_vec);
          state_d = ST_RUN;
        end else if (bus.resume) begin
          state_d = ST_RUN;
        end
      end

      default: begin
        state_d = ST_BOOT;
        pc_d    = RESET_VECTOR;
      end
    endcase
  end

  // State, pc and status registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_BOOT;
      pc_q        <= RESET_VECTOR;
      boot_cnt_q  <= '0;
      ras_ptr_q   <= '0;
      ras_cnt_q   <= '0;
      pc_valid_q  <= 1'b0;
      ras_empty_q <= 1'b1;
      ras_full_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      boot_cnt_q  <= boot_cnt_d;
      ras_ptr_q   <= ras_ptr_d;
      ras_cnt_q   <= ras_cnt_d;
      pc_valid_q  <= (state_d == ST_RUN);
      ras_empty_q <= (ras_cnt_d == CNT_W'(0));
      ras_full_q  <= (ras_cnt_d == CNT_W'(RAS_DEPTH));
    end
  end

  // Return-address storage; cleared on reset so no stale target survives.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < RAS_DEPTH; i++) begin
        ras_mem[i] <= '0;
      end
    end else if (ras_we) begin
      ras_mem[ras_waddr] <= ras_wdata;
    end
  end

  assign bus.pc        = pc_q;
  assign bus.pc_valid  = pc_valid_q;
  assign bus.ras_empty = ras_empty_q;
  assign bus.ras_full  = ras_full_q;
  assign bus.state     = state_q;

endmodule
